// File: rtl/plic_arb_round_ctrl_if.sv
// Bundle between the PLIC control logic, the per-hart round arbiter and the
// round sequencer. The slave side is the sequencer.
interface plic_arb_round_ctrl_if #(
  parameter int ROUND_WIDTH = 5,
  parameter int ID_NUM      = 10,
  parameter int PRIO_BIT    = 5
) ();
  logic                   arb_trigger;
  logic                   ctrl_abort;
  logic [PRIO_BIT-1:0]    hart_threshold;
  logic                   arb_int_req;
  logic [ID_NUM-1:0]      arb_int_id;
  logic [PRIO_BIT-1:0]    arb_int_prio;
  logic                   ctrl_arb_new_arb_start;
  logic [ROUND_WIDTH-1:0] ctrl_arb_select_round;
  logic                   ctrl_busy;
  logic                   res_vld;
  logic                   res_int_req;
  logic [ID_NUM-1:0]      res_int_id;
  logic [PRIO_BIT-1:0]    res_int_prio;

  modport slave (
    input  arb_trigger, ctrl_abort, hart_threshold,
    input  arb_int_req, arb_int_id, arb_int_prio,
    output ctrl_arb_new_arb_start, ctrl_arb_select_round, ctrl_busy,
    output res_vld, res_int_req, res_int_id, res_int_prio
  );

  modport master (
    output arb_trigger, ctrl_abort, hart_threshold,
    output arb_int_req, arb_int_id, arb_int_prio,
    input  ctrl_arb_new_arb_start, ctrl_arb_select_round, ctrl_busy,
    input  res_vld, res_int_req, res_int_id, res_int_prio
  );
endinterface

// File: rtl/plic_arb_round_ctrl.sv
// Round sequencer for the PLIC 32-to-1 arbiter: start pulse, round sweep,
// pipeline flush, then a thresholded one-cycle result.
module plic_arb_round_ctrl #(
  parameter int ROUND_NUM   = 32,
  parameter int ROUND_WIDTH = 5,
  parameter int ID_NUM      = 10,
  parameter int PRIO_BIT    = 5,
  parameter int PIPE_DLY    = 2
) (
  input logic                  arb_clk_i,
  input logic                  plicrst_b_i,
  plic_arb_round_ctrl_if.slave bus_if
);

  localparam int FW = (PIPE_DLY > 1) ? $clog2(PIPE_DLY) : 1;
  localparam logic [ROUND_WIDTH-1:0] LAST_ROUND = ROUND_WIDTH'(ROUND_NUM - 1);
  localparam logic [FW-1:0]          LAST_FLUSH = FW'(PIPE_DLY - 1);

  typedef enum logic [2:0] {IDLE, START, SWEEP, FLUSH, CAPTURE} state_e;

  state_e                 state_q, state_d;
  logic [ROUND_WIDTH-1:0] round_q, round_d;
  logic [FW-1:0]          flush_q, flush_d;
  logic                   rerun_q, rerun_d;
  logic                   res_vld_q;
  logic                   res_req_q;
  logic [ID_NUM-1:0]      res_id_q;
  logic [PRIO_BIT-1:0]    res_prio_q;

  always_ff @(posedge arb_clk_i) begin
    if (!plicrst_b_i) begin
      state_q    <= IDLE;
      round_q    <= '0;
      flush_q    <= '0;
      rerun_q    <= 1'b0;
      res_vld_q  <= 1'b0;
      res_req_q  <= 1'b0;
      res_id_q   <= '0;
      res_prio_q <= '0;
    end else begin
      state_q   <= state_d;
      round_q   <= round_d;
      flush_q   <= flush_d;
      rerun_q   <= rerun_d;
      res_vld_q <= (state_q == CAPTURE);
      if (state_q == CAPTURE) begin
        res_req_q  <= bus_if.arb_int_req && (bus_if.arb_int_prio > bus_if.hart_threshold);
        res_id_q   <= bus_if.arb_int_id;
        res_prio_q <= bus_if.arb_int_prio;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    flush_d = flush_q;
    rerun_d = rerun_q;
    case (state_q)
      IDLE: begin
        round_d = '0;
        if (bus_if.arb_trigger) state_d = START;
      end
      START: begin
        state_d = SWEEP;
        round_d = ROUND_WIDTH'(1);
      end
      SWEEP: begin
        if (round_q == LAST_ROUND) begin
          state_d = FLUSH;
          flush_d = '0;
        end else begin
          round_d = round_q + ROUND_WIDTH'(1);
        end
      end
      FLUSH: begin
        if (flush_q == LAST_FLUSH) begin
          state_d = CAPTURE;
          flush_d = '0;
          round_d = '0;
        end else begin
          flush_d = flush_q + FW'(1);
        end
      end
      CAPTURE: begin
        state_d = (rerun_q || bus_if.arb_trigger) ? START : IDLE;
        rerun_d = 1'b0;
        round_d = '0;
      end
      default: begin
        state_d = IDLE;
        round_d = '0;
        flush_d = '0;
        rerun_d = 1'b0;
      end
    endcase
    // Abort wins over trigger; triggers while busy coalesce into one rerun.
    if (state_q == START || state_q == SWEEP || state_q == FLUSH) begin
      if (bus_if.ctrl_abort) begin
        state_d = START;
        round_d = '0;
        flush_d = '0;
        rerun_d = 1'b0;
      end else if (bus_if.arb_trigger) begin
        rerun_d = 1'b1;
      end
    end
  end

  always_comb begin
    bus_if.ctrl_arb_new_arb_start = (state_q == START);
    bus_if.ctrl_busy              = (state_q != IDLE);
    bus_if.ctrl_arb_select_round  = round_q;
    bus_if.res_vld                = res_vld_q;
    bus_if.res_int_req            = res_req_q;
    bus_if.res_int_id             = res_id_q;
    bus_if.res_int_prio           = res_prio_q;
  end

endmodule

// File: tb/tb_plic_arb_round_ctrl.sv
// Directed bench for plic_arb_round_ctrl: default build plus a ROUND_NUM=4 build.
module tb_plic_arb_round_ctrl;
  localparam int RN = 32;
  localparam int PD = 2;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  plic_arb_round_ctrl_if #(.ROUND_WIDTH(5), .ID_NUM(10), .PRIO_BIT(5)) bus ();
  plic_arb_round_ctrl_if #(.ROUND_WIDTH(5), .ID_NUM(10), .PRIO_BIT(5)) bus4 ();

  plic_arb_round_ctrl #(.ROUND_NUM(RN), .ROUND_WIDTH(5), .ID_NUM(10), .PRIO_BIT(5), .PIPE_DLY(PD)) dut (
    .arb_clk_i(clk), .plicrst_b_i(rst_b), .bus_if(bus.slave));
  plic_arb_round_ctrl #(.ROUND_NUM(4), .ROUND_WIDTH(5), .ID_NUM(10), .PRIO_BIT(5), .PIPE_DLY(PD)) dut4 (
    .arb_clk_i(clk), .plicrst_b_i(rst_b), .bus_if(bus4.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic arb(input logic req, input int id, input int prio, input int thr);
    bus.arb_int_req    = req;
    bus.arb_int_id     = 10'(id);
    bus.arb_int_prio   = 5'(prio);
    bus.hart_threshold = 5'(thr);
  endtask

  task automatic kick(input logic with_abort);
    bus.arb_trigger = 1'b1;
    bus.ctrl_abort  = with_abort;
    step();
    bus.arb_trigger = 1'b0;
    bus.ctrl_abort  = 1'b0;
  endtask

  task automatic res(input string tag, input logic req, input int id, input int prio);
    chk({tag, "_req"}, 32'(bus.res_int_req), 32'(req));
    chk({tag, "_id"}, 32'(bus.res_int_id), id);
    chk({tag, "_prio"}, 32'(bus.res_int_prio), prio);
  endtask

  // Called in cycle 1 of a sweep; checks the cycle-by-cycle outputs against the
  // expected START/res_vld cycles and injects trigger/abort/reset at given cycles.
  task automatic run(input string tag, input int n, input int t1, input int t2, input int ab,
                     input int rs, input int v1, input int v2, input int s1, input int s2);
    int last;
    logic exp_busy;
    for (int c = 1; c <= n; c++) begin
      last = (s2 > 0 && c >= s2) ? s2 : s1;
      chk($sformatf("%s_start_c%0d", tag, c), 32'(bus.ctrl_arb_new_arb_start), 32'(c == s1 || c == s2));
      chk($sformatf("%s_vld_c%0d", tag, c), 32'(bus.res_vld), 32'(c == v1 || c == v2));
      if (rs > 0 && c > rs) begin
        chk($sformatf("%s_busy_c%0d", tag, c), 32'(bus.ctrl_busy), 0);
        chk($sformatf("%s_sel_c%0d", tag, c), 32'(bus.ctrl_arb_select_round), 0);
      end else begin
        exp_busy = (c >= last) && (c <= last + RN + PD);
        chk($sformatf("%s_busy_c%0d", tag, c), 32'(bus.ctrl_busy), 32'(exp_busy));
        if (c >= last && c <= last + RN + PD - 1)
          chk($sformatf("%s_sel_c%0d", tag, c), 32'(bus.ctrl_arb_select_round),
              (c - last < RN - 1) ? c - last : RN - 1);
      end
      bus.arb_trigger = (c == t1 || c == t2);
      bus.ctrl_abort  = (c == ab);
      rst_b           = !(c == rs);
      step();
    end
    bus.arb_trigger = 1'b0;
    bus.ctrl_abort  = 1'b0;
    rst_b           = 1'b1;
  endtask

  initial begin
    bus.arb_trigger = 1'b0; bus.ctrl_abort = 1'b0;
    arb(1'b0, 0, 0, 0);
    bus4.arb_trigger = 1'b0; bus4.ctrl_abort = 1'b0; bus4.hart_threshold = 5'd1;
    bus4.arb_int_req = 1'b1; bus4.arb_int_id = 10'd5; bus4.arb_int_prio = 5'd4;
    step(); step();
    chk("rst_start", 32'(bus.ctrl_arb_new_arb_start), 0);
    chk("rst_sel", 32'(bus.ctrl_arb_select_round), 0);
    chk("rst_busy", 32'(bus.ctrl_busy), 0);
    chk("rst_vld", 32'(bus.res_vld), 0);
    res("rst", 1'b0, 0, 0);
    rst_b = 1'b1;
    step();

    // Single request id 37 prio 5, threshold 2
    arb(1'b1, 37, 5, 2); kick(1'b0);
    run("basic", 40, 0, 0, 0, 0, 36, 0, 1, 0);
    res("basic", 1'b1, 37, 5);

    // Strict compare: prio == threshold gives no request
    arb(1'b1, 37, 5, 5); kick(1'b0);
    run("thr_eq", 40, 0, 0, 0, 0, 36, 0, 1, 0);
    res("thr_eq", 1'b0, 37, 5);

    // Two triggers mid-sweep coalesce into a single rerun
    arb(1'b1, 37, 5, 2); kick(1'b0);
    run("rerun", 75, 10, 20, 0, 0, 36, 71, 1, 36);
    res("rerun", 1'b1, 37, 5);

    // Abort mid-sweep restarts from round 0
    kick(1'b0);
    run("abort", 55, 0, 0, 15, 0, 51, 0, 1, 16);

    // Reset mid-sweep discards the sweep and clears results
    arb(1'b1, 9, 3, 0); kick(1'b0);
    run("rst_mid", 40, 0, 0, 0, 20, 0, 0, 1, 0);
    res("rst_mid", 1'b0, 0, 0);
    kick(1'b0);
    run("after_rst", 40, 0, 0, 0, 0, 36, 0, 1, 0);
    res("after_rst", 1'b1, 9, 3);

    // No arbiter request: id/prio still loaded
    arb(1'b0, 99, 7, 0); kick(1'b0);
    run("noreq", 40, 0, 0, 0, 0, 36, 0, 1, 0);
    res("noreq", 1'b0, 99, 7);

    // Threshold at maximum blocks even the highest priority
    arb(1'b1, 12, 31, 31); kick(1'b0);
    run("thr_max", 40, 0, 0, 0, 0, 36, 0, 1, 0);
    res("thr_max", 1'b0, 12, 31);

    // Threshold raised mid-sweep; abort in CAPTURE is ignored
    arb(1'b1, 37, 5, 0); kick(1'b0);
    bus.hart_threshold = 5'd6;
    run("thr_late", 40, 0, 0, 35, 0, 36, 0, 1, 0);
    res("thr_late", 1'b0, 37, 5);

    // Abort alone in IDLE does nothing
    bus.ctrl_abort = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step();
      chk($sformatf("idle_abort_busy_c%0d", c), 32'(bus.ctrl_busy), 0);
      chk($sformatf("idle_abort_start_c%0d", c), 32'(bus.ctrl_arb_new_arb_start), 0);
    end
    bus.ctrl_abort = 1'b0;

    // Abort together with trigger in IDLE is a normal start
    arb(1'b1, 21, 9, 3); kick(1'b1);
    run("idle_abtrig", 40, 0, 0, 0, 0, 36, 0, 1, 0);
    res("idle_abtrig", 1'b1, 21, 9);

    // ROUND_NUM=4 build: result after 4+2+2 cycles
    bus4.arb_trigger = 1'b1;
    step();
    bus4.arb_trigger = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      chk($sformatf("r4_start_c%0d", c), 32'(bus4.ctrl_arb_new_arb_start), 32'(c == 1));
      chk($sformatf("r4_vld_c%0d", c), 32'(bus4.res_vld), 32'(c == 8));
      chk($sformatf("r4_busy_c%0d", c), 32'(bus4.ctrl_busy), 32'(c <= 7));
      if (c <= 4) chk($sformatf("r4_sel_c%0d", c), 32'(bus4.ctrl_arb_select_round), c - 1);
      step();
    end
    chk("r4_req", 32'(bus4.res_int_req), 1);
    chk("r4_id", 32'(bus4.res_int_id), 5);
    chk("r4_prio", 32'(bus4.res_int_prio), 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
